// File: rtl/morse_serializer.sv
// Morse serializer: accepts a packet of BCD digits over valid/ready and keys
// each digit out on key_out as five dot/dash symbols with standard unit timing.
// Digits >= 10 are skipped and flagged on err rather than sent as '0'.
module morse_serializer #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned UNIT_CYCLES = 4,
   parameter bit          WORD_GAP_EN = 1'b1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [4*NUM_DIGITS-1:0]            in_digits,
   input  logic [$clog2(NUM_DIGITS+1)-1:0]    in_len,
   output logic                               key_out,
   output logic                               busy,
   output logic [4:0]                         cur_code,
   output logic                               done,
   output logic                               err
);

   localparam int unsigned LW = $clog2(NUM_DIGITS + 1);
   localparam int unsigned CW = $clog2(7 * UNIT_CYCLES + 1);
   localparam int unsigned DW = 4 * NUM_DIGITS;

   // Counter reload values are "cycles minus one" since the counter ends at zero.
   localparam logic [CW-1:0] DOT_LAST  = CW'(UNIT_CYCLES - 1);
   localparam logic [CW-1:0] DASH_LAST = CW'(3 * UNIT_CYCLES - 1);
   localparam logic [CW-1:0] WORD_LAST = CW'(7 * UNIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MARK,
      S_SYM_GAP,
      S_DIG_GAP,
      S_WORD_GAP
   } state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [2:0]      sym, sym_n;
   logic [LW-1:0]   dig, dig_n;
   logic [DW-1:0]   digits_q, digits_n;
   logic [LW-1:0]   len_q, len_n;
   logic [4:0]      code_n;
   logic            err_n;
   logic            done_n;

   logic            len_bad;
   logic            acc_found, acc_skip;
   logic [LW-1:0]   acc_idx;
   logic [4:0]      acc_code;
   logic            nxt_found, nxt_skip;
   logic [LW-1:0]   nxt_idx;
   logic [4:0]      gap_code;

   // Five-symbol Morse pattern for a BCD digit, bit4 sent first, 1 = dot.
   function automatic logic [4:0] encode(input logic [3:0] d);
      logic [4:0] c;
      case (d)
         4'd0:    c = 5'b00000;
         4'd1:    c = 5'b10000;
         4'd2:    c = 5'b11000;
         4'd3:    c = 5'b11100;
         4'd4:    c = 5'b11110;
         4'd5:    c = 5'b11111;
         4'd6:    c = 5'b01111;
         4'd7:    c = 5'b00111;
         4'd8:    c = 5'b00011;
         4'd9:    c = 5'b00001;
         default: c = 5'b00000;
      endcase
      return c;
   endfunction

   // Symbol s of a code, s = 0 being the first symbol keyed.
   function automatic logic code_bit(input logic [4:0] c, input logic [2:0] s);
      logic b;
      case (s)
         3'd0:    b = c[4];
         3'd1:    b = c[3];
         3'd2:    b = c[2];
         3'd3:    b = c[1];
         default: b = c[0];
      endcase
      return b;
   endfunction

   // Counter reload for a mark: dot is one unit, dash three.
   function automatic logic [CW-1:0] mark_last(input logic is_dot);
      return is_dot ? DOT_LAST : DASH_LAST;
   endfunction

   // First valid digit at or after start within len; flags any invalid digit
   // passed over (including trailing invalid digits when nothing valid remains).
   function automatic void find_next(
      input  logic [DW-1:0] dg,
      input  logic [LW-1:0] len,
      input  logic [LW-1:0] start,
      output logic          found,
      output logic          skipped,
      output logic [LW-1:0] idx
   );
      found   = 1'b0;
      skipped = 1'b0;
      idx     = '0;
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
         if (!found && (k >= int'(start)) && (k < int'(len))) begin
            if (dg[4*k +: 4] < 4'd10) begin
               found = 1'b1;
               idx   = LW'(k);
            end else begin
               skipped = 1'b1;
            end
         end
      end
   endfunction

   // Digit lookahead for packet accept and for the end of each emitted digit.
   always_comb begin
      len_bad = (in_len == '0) || (32'(in_len) > NUM_DIGITS);
      find_next(in_digits, in_len, '0, acc_found, acc_skip, acc_idx);
      find_next(digits_q, len_q, dig + LW'(1), nxt_found, nxt_skip, nxt_idx);
      acc_code = encode(in_digits[4*acc_idx +: 4]);
      gap_code = encode(digits_q[4*dig +: 4]);
   end

   // Next-state and datapath logic; the digit load is folded into the
   // accept and inter-digit-gap transitions so it costs no cycle.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      sym_n    = sym;
      dig_n    = dig;
      digits_n = digits_q;
      len_n    = len_q;
      code_n   = cur_code;
      err_n    = err;
      done_n   = 1'b0;

      case (state)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               digits_n = in_digits;
               len_n    = in_len;
               err_n    = 1'b0;
               if (len_bad) begin
                  err_n  = 1'b1;
                  done_n = 1'b1;
               end else begin
                  if (acc_skip) begin
                     err_n = 1'b1;
                  end
                  if (acc_found) begin
                     state_n = S_MARK;
                     dig_n   = acc_idx;
                     sym_n   = 3'd0;
                     code_n  = acc_code;
                     cnt_n   = mark_last(acc_code[4]);
                  end else if (WORD_GAP_EN) begin
                     state_n = S_WORD_GAP;
                     cnt_n   = WORD_LAST;
                  end else begin
                     done_n = 1'b1;
                  end
               end
            end
         end

         S_MARK: begin
            if (cnt == '0) begin
               if (sym == 3'd4) begin
                  if (nxt_skip) begin
                     err_n = 1'b1;
                  end
                  if (nxt_found) begin
                     state_n = S_DIG_GAP;
                     dig_n   = nxt_idx;
                     cnt_n   = DASH_LAST;
                  end else if (WORD_GAP_EN) begin
                     state_n = S_WORD_GAP;
                     cnt_n   = WORD_LAST;
                  end else begin
                     state_n = S_IDLE;
                     done_n  = 1'b1;
                  end
               end else begin
                  state_n = S_SYM_GAP;
                  cnt_n   = DOT_LAST;
               end
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end

         S_SYM_GAP: begin
            if (cnt == '0) begin
               state_n = S_MARK;
               sym_n   = sym + 3'd1;
               cnt_n   = mark_last(code_bit(cur_code, sym + 3'd1));
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end

         S_DIG_GAP: begin
            if (cnt == '0) begin
               state_n = S_MARK;
               sym_n   = 3'd0;
               code_n  = gap_code;
               cnt_n   = mark_last(gap_code[4]);
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end

         S_WORD_GAP: begin
            if (cnt == '0) begin
               state_n = S_IDLE;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Datapath and registered outputs, derived from the next state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt      <= '0;
         sym      <= '0;
         dig      <= '0;
         digits_q <= '0;
         len_q    <= '0;
         cur_code <= '0;
         err      <= 1'b0;
         done     <= 1'b0;
         key_out  <= 1'b0;
         in_ready <= 1'b1;
         busy     <= 1'b0;
      end else begin
         cnt      <= cnt_n;
         sym      <= sym_n;
         dig      <= dig_n;
         digits_q <= digits_n;
         len_q    <= len_n;
         cur_code <= code_n;
         err      <= err_n;
         done     <= done_n;
         key_out  <= (state_n == S_MARK);
         in_ready <= (state_n == S_IDLE);
         busy     <= (state_n != S_IDLE);
      end
   end

endmodule
